fetch_queue: RTL and testbench



---
 rtl/isa_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA constants shared by fetch and decode: opcode/funct encodings, field
// positions and the fetch-stage state encoding.
package isa_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_JMP = 6'b000010;
  localparam logic [5:0] OP_HLT = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with push/pop/flush and an occupancy count.
// Flush wins over push and pop in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the count qualifies what is readable.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: sequential PC generation against a 1-cycle imem, a small
// instruction queue toward decode, HLT pre-decode and redirect flush.
module fetch_queue import isa_pkg::*; #(
  parameter int               DEPTH    = 4,
  parameter int               PC_W     = 32,
  parameter int               INSTR_W  = 32,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [5:0]       HLT_OP   = 6'b111111
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_dec_valid,
  output logic [INSTR_W-1:0] o_dec_instr,
  output logic [PC_W-1:0]    o_dec_pc,
  input  logic               i_dec_ready,
  input  logic               i_redirect_valid,
  input  logic [PC_W-1:0]    i_redirect_pc,
  output logic               o_halted
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              EW      = INSTR_W + PC_W;
  localparam logic [CW:0]     DEPTH_L = (CW + 1)'(DEPTH);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_inflight;
  fetch_state_e    r_state;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic [EW-1:0]   w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_hlt_seen;
  logic            w_req;

  assign w_push     = r_inflight && !i_redirect_valid;
  assign w_hlt_seen = w_push && (i_imem_rdata[OPC_MSB:OPC_LSB] == HLT_OP);
  assign w_occ      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

  // Credit: queued plus in-flight words never exceed DEPTH. The HLT word
  // being pushed already suppresses the request that would follow it.
  assign w_req = i_rst_n && (r_state == ST_RUN) && !i_redirect_valid &&
                 !w_hlt_seen && (w_occ < DEPTH_L);

  assign w_pop = o_dec_valid && i_dec_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_state    <= ST_RUN;
    end else if (i_redirect_valid) begin
      r_pc       <= i_redirect_pc;
      r_inflight <= 1'b0;
      r_state    <= ST_RUN;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + PC_W'(4);
      end
      if (w_hlt_seen) r_state <= ST_HALTED;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_wdata ({i_imem_rdata, r_req_pc}),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;
  assign o_dec_valid = (w_count != '0);
  assign o_dec_instr = o_dec_valid ? w_head[EW-1:PC_W] : '0;
  assign o_dec_pc    = o_dec_valid ? w_head[PC_W-1:0]  : '0;
  assign o_halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed tables/sequences plus random
// traffic against a queue-based behavioural model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req, dvalid, drdy, rv, halted;
  logic [31:0] addr, rdata, dinstr, dpc, rpc;

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  logic        hlt_en = 1'b0;
  logic [31:0] hlt_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req       (req),
    .o_imem_addr      (addr),
    .i_imem_rdata     (rdata),
    .o_dec_valid      (dvalid),
    .o_dec_instr      (dinstr),
    .o_dec_pc         (dpc),
    .i_dec_ready      (drdy),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .o_halted         (halted)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    if (hlt_en && a == hlt_addr) return 32'hFC00_0000;
    return 32'h20 + a;
  endfunction

  always @(posedge clk) rdata <= req ? word(addr) : 32'hDEAD_BEEF;

  // Behavioural model: a queue of {instr, pc} plus fetch PC / halt flag.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc, m_req_pc;
  bit          m_inflight, m_halted;
  bit          e_push, e_hlt, e_req, e_valid, e_halted;
  logic [31:0] e_addr, e_instr, e_pc;

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0; m_req_pc = 32'h0; m_inflight = 0; m_halted = 0;
  endtask

  task automatic model_comb();
    logic [31:0] w;
    w       = word(m_req_pc);
    e_push  = rst_n && m_inflight && !rv;
    e_hlt   = e_push && (w[31:26] == 6'h3F);
    e_req   = rst_n && !m_halted && !rv && !e_hlt &&
              (m_q.size() + int'(m_inflight) < DEPTH);
    e_valid = rst_n && (m_q.size() != 0);
    e_instr = e_valid ? m_q[0].instr : 32'h0;
    e_pc    = e_valid ? m_q[0].pc : 32'h0;
    e_addr  = rst_n ? m_pc : 32'h0;
    e_halted = rst_n && m_halted;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (rv) begin
      m_q.delete();
      m_pc = rpc; m_inflight = 0; m_halted = 0;
    end else begin
      if (e_valid && drdy) void'(m_q.pop_front());
      if (e_push) begin
        m_q.push_back('{instr: word(m_req_pc), pc: m_req_pc});
        if (e_hlt) m_halted = 1;
      end
      m_inflight = e_req;
      if (e_req) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit rdy, input bit r, input logic [31:0] p);
    drdy = rdy; rv = r; rpc = p;
    @(negedge clk);
    model_comb();
    vectors++;
    if ({req, addr, dvalid, dinstr, dpc, halted} !==
        {e_req, e_addr, e_valid, e_instr, e_pc, e_halted}) begin
      miscompares++;
      $display("FAIL model cycle %0d: got req=%b addr=%h vld=%b instr=%h pc=%h hlt=%b, expected req=%b addr=%h vld=%b instr=%h pc=%h hlt=%b",
               cyc_no, req, addr, dvalid, dinstr, dpc, halted,
               e_req, e_addr, e_valid, e_instr, e_pc, e_halted);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    cyc_no++;
    #1;
  endtask

  task automatic cyc(input bit rdy, input bit r, input logic [31:0] p);
    apply(rdy, r, p);
    advance();
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases after two edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req",    {31'b0, req},    32'h0);
    check("rst_valid",  {31'b0, dvalid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_instr",  dinstr,          32'h0);
    check("rst_pc",     dpc,             32'h0);
    apply(0, 0, 0);
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int nreq, ndel;
    logic [31:0] last_pc, last_instr;

    tbl[0] = '{1, 1, 32'h00, 0, 32'h0, 32'h0};
    tbl[1] = '{1, 1, 32'h04, 0, 32'h0, 32'h0};
    tbl[2] = '{1, 1, 32'h08, 1, 32'h0, 32'h20};
    tbl[3] = '{1, 1, 32'h0C, 1, 32'h4, 32'h24};
    tbl[4] = '{1, 1, 32'h10, 1, 32'h8, 32'h28};
    tbl[5] = '{1, 1, 32'h14, 1, 32'hC, 32'h2C};

    drdy = 0; rv = 0; rpc = 0;
    model_reset();
    #2;

    // Reset release and streaming startup
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].rdy, 0, 0);
      check($sformatf("tbl%0d_req", i),   {31'b0, req},    {31'b0, tbl[i].exp_req});
      check($sformatf("tbl%0d_addr", i),  addr,            tbl[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), {31'b0, dvalid}, {31'b0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_pc", i),    dpc,             tbl[i].exp_pc);
      check($sformatf("tbl%0d_instr", i), dinstr,          tbl[i].exp_instr);
      advance();
    end

    // Backpressure: queue fills, requests stop, then drains in order
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    apply(1, 0, 0);
    check("bp_req_stopped", {31'b0, req},    32'h0);
    check("bp_valid",       {31'b0, dvalid}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) apply(1, 0, 0);
      check($sformatf("bp_drain%0d_pc", k), dpc, 32'(4 * k));
      advance();
    end
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);

    // Redirect with three entries queued and one response in flight
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    apply(0, 1, 32'h100);
    check("rd_req_in_redirect", {31'b0, req}, 32'h0);
    advance();
    apply(1, 0, 0);
    check("rd_valid_flushed", {31'b0, dvalid}, 32'h0);
    check("rd_req_resume",    {31'b0, req},    32'h1);
    check("rd_addr_resume",   addr,            32'h100);
    advance();
    apply(1, 0, 0);
    check("rd_stale_dropped", {31'b0, dvalid}, 32'h0);
    advance();
    apply(1, 0, 0);
    check("rd_first_pc",    dpc,    32'h100);
    check("rd_first_instr", dinstr, 32'h120);
    advance();

    // HLT at 0x10 stops fetch; queued words, HLT included, still drain
    hlt_en = 1; hlt_addr = 32'h10;
    do_reset();
    nreq = 0; ndel = 0; last_pc = 0; last_instr = 0;
    for (int i = 0; i < 30; i++) begin
      apply(1, 0, 0);
      if (req === 1'b1) nreq++;
      if (dvalid === 1'b1) begin
        ndel++; last_pc = dpc; last_instr = dinstr;
      end
      advance();
    end
    check("hlt_requests",   32'(nreq),   32'd5);
    check("hlt_delivered",  32'(ndel),   32'd5);
    check("hlt_last_pc",    last_pc,     32'h10);
    check("hlt_last_instr", last_instr,  32'hFC00_0000);
    apply(1, 0, 0);
    check("hlt_halted", {31'b0, halted}, 32'h1);
    advance();

    // Redirect out of HALTED
    apply(1, 1, 32'h40);
    check("hr_req_in_redirect", {31'b0, req}, 32'h0);
    advance();
    apply(1, 0, 0);
    check("hr_halted_clear", {31'b0, halted}, 32'h0);
    check("hr_req",          {31'b0, req},    32'h1);
    check("hr_addr",         addr,            32'h40);
    advance();
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);

    // Reset with the queue full, then restart at RESET_PC
    hlt_en = 0;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    do_reset();
    apply(1, 0, 0);
    check("rr_req",   {31'b0, req},    32'h1);
    check("rr_addr",  addr,            32'h0);
    check("rr_valid", {31'b0, dvalid}, 32'h0);
    advance();
    cyc(1, 0, 0);
    apply(1, 0, 0);
    check("rr_first_pc",    dpc,    32'h0);
    check("rr_first_instr", dinstr, 32'h20);
    advance();

    // Random traffic against the model
    hlt_en = 1; hlt_addr = 32'h80;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          r_rdy, r_rv;
      logic [31:0] r_pc;
      r_rdy = ($urandom_range(0, 9) < 7);
      r_rv  = ($urandom_range(0, 99) < 3);
      r_pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc(r_rdy, r_rv, r_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
